// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 data mux: walks the enabled channels in ascending order,
// waits for the mux to settle, then offers each sample on a valid/ready handshake.
module mux_scan_sequencer #(
  parameter int DW         = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    chan_en,
  input  logic [DW-1:0] mux_y,
  output logic          s0,
  output logic          s1,
  output logic          s2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_chan,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OFFER  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    mask_q, mask_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [2:0]    out_chan_q, out_chan_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    higher_s;
  logic          has_next_s;
  logic          hs_s;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  // Enabled channels strictly above the current select; shifting past bit 7 yields an empty set.
  assign higher_s   = mask_q & ~((8'd2 << sel_q) - 8'd1);
  assign has_next_s = |higher_s;
  assign hs_s       = out_valid_q & out_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      mask_q      <= 8'd0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (chan_en != 8'd0)) state_d = SETTLE;
        else                            state_d = IDLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = OFFER;
        else                   state_d = SETTLE;
      end
      OFFER: begin
        if (hs_s) begin
          if (has_next_s) state_d = SETTLE;
          else            state_d = IDLE;
        end else begin
          state_d = OFFER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    sel_d       = sel_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (chan_en != 8'd0)) begin
          mask_d = chan_en;
          sel_d  = lowest_set(chan_en);
          cnt_d  = 4'd0;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          out_data_d  = mux_y;
          out_chan_d  = sel_q;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      OFFER: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          if (has_next_s) begin
            sel_d = lowest_set(higher_s);
            cnt_d = 4'd0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign s2        = sel_q[2];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: mux inputs tied to their channel index, so mux_y equals the
// select. A table of scan records plus random masks with random backpressure and noise.
module tb_mux_scan_sequencer;
  localparam int DW     = 3;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    chan_en;
  logic [DW-1:0] mux_y;
  logic          s0, s1, s2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_chan;
  logic          busy;
  logic          done;
  logic [2:0]    sel;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int hs_last = -1;

  typedef struct {
    logic [7:0] mask;
    int         stall_chan;
    int         stall_len;
    bit         noise;
    int         exp_n;
    int         exp_last;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  assign sel   = {s2, s1, s0};
  assign mux_y = sel;

  mux_scan_sequencer #(.DW(DW), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan_en(chan_en), .mux_y(mux_y),
    .s0(s0), .s1(s1), .s2(s2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .busy(busy), .done(done)
  );

  // Observed handshakes and done pulses
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      hs_cnt  <= hs_cnt + 1;
      hs_last <= int'(out_chan);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_chan"}, 32'(out_chan), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Called at a negedge with the DUT idle; walks the scan the spec's rules predict.
  task automatic run_scan(input logic [7:0] mask, input int stall_chan, input int stall_len,
                          input bit noise);
    int chans[$];
    int hold;
    for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
    start     = 1'b1;
    chan_en   = mask;
    out_ready = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (chans.size() == 0) begin
      chk("empty_done", 32'(done), 1);
      chk("empty_busy", 32'(busy), 0);
      chk("empty_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("empty_done_drop", 32'(done), 0);
      chk("empty_valid2", 32'(out_valid), 0);
      return;
    end
    for (int k = 0; k < chans.size(); k++) begin
      for (int n = 0; n < SETTLE; n++) begin
        chk("settle_sel", 32'(sel), chans[k]);
        chk("settle_valid", 32'(out_valid), 0);
        chk("settle_busy", 32'(busy), 1);
        chk("settle_done", 32'(done), 0);
        if (noise) begin
          start     = 1'($urandom);
          chan_en   = 8'($urandom);
          out_ready = 1'($urandom);
        end
        @(negedge clk);
      end
      hold = (chans[k] == stall_chan) ? stall_len : (noise ? $urandom_range(0, 2) : 0);
      for (int j = 0; j <= hold; j++) begin
        chk("offer_valid", 32'(out_valid), 1);
        chk("offer_data", 32'(out_data), chans[k]);
        chk("offer_chan", 32'(out_chan), chans[k]);
        chk("offer_sel", 32'(sel), chans[k]);
        chk("offer_busy", 32'(busy), 1);
        chk("offer_done", 32'(done), 0);
        out_ready = (j == hold);
        if (noise) begin
          start   = 1'($urandom);
          chan_en = 8'($urandom);
        end
        @(negedge clk);
      end
      chk("hs_valid_drop", 32'(out_valid), 0);
      if (k + 1 == chans.size()) begin
        chk("end_done", 32'(done), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_sel_hold", 32'(sel), chans[k]);
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("end_done_drop", 32'(done), 0);
        chk("end_idle_busy", 32'(busy), 0);
        chk("end_idle_sel", 32'(sel), chans[k]);
        chk("end_idle_valid", 32'(out_valid), 0);
      end else begin
        out_ready = noise ? 1'($urandom) : 1'b0;
      end
    end
  endtask

  task automatic scan_and_count(input logic [7:0] mask, input int stall_chan,
                                input int stall_len, input bit noise,
                                input int exp_n, input int exp_last);
    int h0, d0;
    h0 = hs_cnt;
    d0 = done_cnt;
    run_scan(mask, stall_chan, stall_len, noise);
    @(negedge clk);
    chk("scan_samples", 32'(hs_cnt - h0), 32'(exp_n));
    chk("scan_done_pulses", 32'(done_cnt - d0), 1);
    if (exp_n > 0) chk("scan_last_chan", 32'(hs_last), 32'(exp_last));
  endtask

  initial begin
    int d0, m_n, m_last;
    logic [7:0] m;

    vecs[0] = '{mask: 8'hFF,        stall_chan: -1, stall_len: 0, noise: 1'b0, exp_n: 8, exp_last: 7};
    vecs[1] = '{mask: 8'b1000_0101, stall_chan: -1, stall_len: 0, noise: 1'b0, exp_n: 3, exp_last: 7};
    vecs[2] = '{mask: 8'b1000_0101, stall_chan:  2, stall_len: 5, noise: 1'b0, exp_n: 3, exp_last: 7};
    vecs[3] = '{mask: 8'h00,        stall_chan: -1, stall_len: 0, noise: 1'b0, exp_n: 0, exp_last: -1};
    vecs[4] = '{mask: 8'h81,        stall_chan: -1, stall_len: 0, noise: 1'b1, exp_n: 2, exp_last: 7};
    vecs[5] = '{mask: 8'h80,        stall_chan: -1, stall_len: 0, noise: 1'b0, exp_n: 1, exp_last: 7};
    vecs[6] = '{mask: 8'h01,        stall_chan: -1, stall_len: 0, noise: 1'b1, exp_n: 1, exp_last: 0};
    vecs[7] = '{mask: 8'h5A,        stall_chan:  3, stall_len: 2, noise: 1'b1, exp_n: 4, exp_last: 6};

    rst_n     = 1'b0;
    start     = 1'b0;
    chan_en   = 8'd0;
    out_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    foreach (vecs[v]) begin
      scan_and_count(vecs[v].mask, vecs[v].stall_chan, vecs[v].stall_len, vecs[v].noise,
                     vecs[v].exp_n, vecs[v].exp_last);
    end

    // Reset while settling: outputs clear without a clock edge, no done pulse.
    d0      = done_cnt;
    start   = 1'b1;
    chan_en = 8'h0C;
    @(negedge clk);
    start = 1'b0;
    chk("rst_settle_busy", 32'(busy), 1);
    chk("rst_settle_sel", 32'(sel), 2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_settle");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_settle_no_done", 32'(done_cnt - d0), 0);
    chk_all_zero("rst_settle_idle");

    // Reset while offering a sample.
    d0      = done_cnt;
    start   = 1'b1;
    chan_en = 8'h50;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE) @(negedge clk);
    chk("rst_offer_valid", 32'(out_valid), 1);
    chk("rst_offer_data", 32'(out_data), 4);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_offer");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_offer_no_done", 32'(done_cnt - d0), 0);
    scan_and_count(8'b1000_0101, -1, 0, 1'b0, 3, 7);

    // Random masks against a channel-list model.
    for (int r = 0; r < 25; r++) begin
      m      = 8'($urandom);
      m_n    = $countones(m);
      m_last = -1;
      for (int i = 0; i < 8; i++) if (m[i]) m_last = i;
      scan_and_count(m, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 1'b1,
                     m_n, m_last);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
